// File: rtl/alu_mdu_sequencer.sv
// ALU op decoder plus an iterative signed multiply/divide unit with HI/LO result registers.
// Optional build macro MDU_UNSIGNED_EN adds multu/divu (unsigned operands, no sign fix-up).
module alu_mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ctrl,
    input  logic [5:0]       funct,
    output logic [3:0]       alu_op,
    output logic             illegal,
    input  logic             mdu_start,
    output logic             is_mdu,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_r, state_nx_s;
    logic [3:0]           alu_op_s;
    logic                 illegal_s, mdu_s, div_s, uns_s;
    logic                 launch_s, a_neg_s, b_neg_s, b_zero_s;
    logic [WIDTH-1:0]     a_abs_s, b_abs_s;
    logic [2*WIDTH-1:0]   acc_r, mul_next_s, div_next_s, fix_s;
    logic [WIDTH-1:0]     d_r, hi_r, lo_r, quo_s, rem_s;
    logic [WIDTH:0]       mul_sum_s, div_sh_s, div_diff_s;
    logic [CW-1:0]        cnt_r;
    logic                 div_r, dz_r, pneg_r, rneg_r;

    // Instruction decode: ctrl selects the op directly except for R-type (ctrl=010)
    always_comb begin
        alu_op_s  = 4'b0000;
        illegal_s = 1'b0;
        mdu_s     = 1'b0;
        div_s     = 1'b0;
        uns_s     = 1'b0;
        case (ctrl)
            3'b000: alu_op_s = 4'b0010;
            3'b001: alu_op_s = 4'b0110;
            3'b011: alu_op_s = 4'b0111;
            3'b100: alu_op_s = 4'b0000;
            3'b101: alu_op_s = 4'b0001;
            3'b110: alu_op_s = 4'b0011;
            3'b111: begin alu_op_s = 4'b1110; mdu_s = 1'b1; end
            3'b010: begin
                case (funct)
                    6'b001000, 6'b001001,
                    6'b100000, 6'b100001: alu_op_s = 4'b0010;
                    6'b100010, 6'b100011: alu_op_s = 4'b0110;
                    6'b100100: alu_op_s = 4'b0000;
                    6'b100101: alu_op_s = 4'b0001;
                    6'b100110: alu_op_s = 4'b0011;
                    6'b100111: alu_op_s = 4'b0100;
                    6'b000000: alu_op_s = 4'b1000;
                    6'b000100: alu_op_s = 4'b1001;
                    6'b000010: alu_op_s = 4'b1010;
                    6'b000110: alu_op_s = 4'b1011;
                    6'b000011: alu_op_s = 4'b1100;
                    6'b000111: alu_op_s = 4'b1101;
                    6'b101001: alu_op_s = 4'b0101;
                    6'b101010: alu_op_s = 4'b0111;
                    6'b011000: begin alu_op_s = 4'b1110; mdu_s = 1'b1; end
                    6'b011010: begin alu_op_s = 4'b1111; mdu_s = 1'b1; div_s = 1'b1; end
`ifdef MDU_UNSIGNED_EN
                    6'b011001: begin alu_op_s = 4'b1110; mdu_s = 1'b1; uns_s = 1'b1; end
                    6'b011011: begin alu_op_s = 4'b1111; mdu_s = 1'b1; div_s = 1'b1; uns_s = 1'b1; end
`endif
                    default: begin alu_op_s = 4'b0000; illegal_s = 1'b1; end
                endcase
            end
            default: alu_op_s = 4'b0000;
        endcase
    end

    assign launch_s = (state_r == IDLE) & mdu_start & mdu_s;
    assign a_neg_s  = ~uns_s & op_a[WIDTH-1];
    assign b_neg_s  = ~uns_s & op_b[WIDTH-1];
    assign a_abs_s  = a_neg_s ? -op_a : op_a;
    assign b_abs_s  = b_neg_s ? -op_b : op_b;
    assign b_zero_s = (op_b == {WIDTH{1'b0}});

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}
    assign mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, d_r} : {(WIDTH+1){1'b0}});
    assign mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    assign div_sh_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    assign div_diff_s = div_sh_s - {1'b0, d_r};
    assign div_next_s = div_diff_s[WIDTH] ? {div_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0}
                                          : {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    assign quo_s = acc_r[WIDTH-1:0];
    assign rem_s = acc_r[2*WIDTH-1:WIDTH];

    // Sign correction of the magnitude result (divide-by-zero result passes through raw)
    always_comb begin
        fix_s = acc_r;
        if (dz_r) begin
            fix_s = acc_r;
        end else if (!div_r) begin
            fix_s = pneg_r ? -acc_r : acc_r;
        end else begin
            fix_s = {(rneg_r ? -rem_s : rem_s), (pneg_r ? -quo_s : quo_s)};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    state_nx_s = (div_s && b_zero_s) ? FIX : RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CW'(WIDTH - 1)) begin
                    state_nx_s = FIX;
                end else begin
                    state_nx_s = RUN;
                end
            end
            FIX:     state_nx_s = DONE;
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Operand capture, one iteration per RUN cycle, HI/LO write on leaving FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= {(2*WIDTH){1'b0}};
            d_r    <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            div_r  <= 1'b0;
            dz_r   <= 1'b0;
            pneg_r <= 1'b0;
            rneg_r <= 1'b0;
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (launch_s) begin
                        cnt_r  <= {CW{1'b0}};
                        div_r  <= div_s;
                        pneg_r <= a_neg_s ^ b_neg_s;
                        rneg_r <= div_s & a_neg_s;
                        dz_r   <= div_s & b_zero_s;
                        if (!div_s) begin
                            acc_r <= {{WIDTH{1'b0}}, b_abs_s};
                            d_r   <= a_abs_s;
                        end else if (b_zero_s) begin
                            acc_r <= {op_a, {WIDTH{1'b1}}};
                            d_r   <= {WIDTH{1'b0}};
                        end else begin
                            acc_r <= {{WIDTH{1'b0}}, a_abs_s};
                            d_r   <= b_abs_s;
                        end
                    end
                end
                RUN: begin
                    acc_r <= div_r ? div_next_s : mul_next_s;
                    cnt_r <= cnt_r + CW'(1);
                end
                FIX: begin
                    hi_r <= fix_s[2*WIDTH-1:WIDTH];
                    lo_r <= fix_s[WIDTH-1:0];
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign alu_op   = alu_op_s;
    assign illegal  = illegal_s;
    assign is_mdu   = mdu_s;
    assign mdu_busy = (state_r != IDLE);
    assign mdu_done = (state_r == DONE);
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_alu_mdu_sequencer.sv
// Directed self-checking bench for alu_mdu_sequencer (WIDTH=32), expected values hand-computed.
module tb_alu_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ctrl;
    logic [5:0]  funct;
    logic [3:0]  alu_op;
    logic        illegal;
    logic        mdu_start;
    logic        is_mdu;
    logic [31:0] op_a, op_b;
    logic        mdu_busy, mdu_done;
    logic [31:0] hi, lo;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    alu_mdu_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .funct(funct), .alu_op(alu_op),
        .illegal(illegal), .mdu_start(mdu_start), .is_mdu(is_mdu), .op_a(op_a),
        .op_b(op_b), .mdu_busy(mdu_busy), .mdu_done(mdu_done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // {ctrl, funct, alu_op, illegal, is_mdu}
    logic [14:0] dtab [0:27] = '{
        {3'b000, 6'b011010, 4'b0010, 1'b0, 1'b0},
        {3'b001, 6'b011010, 4'b0110, 1'b0, 1'b0},
        {3'b011, 6'b011010, 4'b0111, 1'b0, 1'b0},
        {3'b100, 6'b011010, 4'b0000, 1'b0, 1'b0},
        {3'b101, 6'b011010, 4'b0001, 1'b0, 1'b0},
        {3'b110, 6'b011010, 4'b0011, 1'b0, 1'b0},
        {3'b111, 6'b000000, 4'b1110, 1'b0, 1'b1},
        {3'b010, 6'b001001, 4'b0010, 1'b0, 1'b0},
        {3'b010, 6'b100000, 4'b0010, 1'b0, 1'b0},
        {3'b010, 6'b100001, 4'b0010, 1'b0, 1'b0},
        {3'b010, 6'b100010, 4'b0110, 1'b0, 1'b0},
        {3'b010, 6'b100011, 4'b0110, 1'b0, 1'b0},
        {3'b010, 6'b100100, 4'b0000, 1'b0, 1'b0},
        {3'b010, 6'b100101, 4'b0001, 1'b0, 1'b0},
        {3'b010, 6'b100110, 4'b0011, 1'b0, 1'b0},
        {3'b010, 6'b100111, 4'b0100, 1'b0, 1'b0},
        {3'b010, 6'b000000, 4'b1000, 1'b0, 1'b0},
        {3'b010, 6'b000100, 4'b1001, 1'b0, 1'b0},
        {3'b010, 6'b000010, 4'b1010, 1'b0, 1'b0},
        {3'b010, 6'b000110, 4'b1011, 1'b0, 1'b0},
        {3'b010, 6'b000011, 4'b1100, 1'b0, 1'b0},
        {3'b010, 6'b000111, 4'b1101, 1'b0, 1'b0},
        {3'b010, 6'b101001, 4'b0101, 1'b0, 1'b0},
        {3'b010, 6'b101010, 4'b0111, 1'b0, 1'b0},
        {3'b010, 6'b011000, 4'b1110, 1'b0, 1'b1},
        {3'b010, 6'b011010, 4'b1111, 1'b0, 1'b1},
        {3'b010, 6'b001000, 4'b0010, 1'b0, 1'b0},
        {3'b010, 6'b111111, 4'b0000, 1'b1, 1'b0}
    };

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Launch one MDU op; while busy keep start high and scramble operands (both must be ignored)
    task automatic run_mdu(input string tag, input logic [2:0] c, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat);
        int lat;
        logic busy_drop;
        @(negedge clk);
        ctrl = c; funct = f; op_a = a; op_b = b; mdu_start = 1'b1;
        @(posedge clk); #1;
        check({tag, "_busy_k1"}, 64'(mdu_busy), 64'd1);
        op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0003;
        lat = 0; busy_drop = 1'b0;
        while (!mdu_done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (!mdu_busy) busy_drop = 1'b1;
        end
        mdu_start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_held"}, 64'(busy_drop), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        @(posedge clk); #1;
        check({tag, "_done_busy_after"}, 64'({mdu_done, mdu_busy}), 64'd0);
        repeat (3) @(posedge clk); #1;
        check({tag, "_hold"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        logic saw_done;
        rst_n = 1'b0; ctrl = 3'b000; funct = 6'b000000; mdu_start = 1'b0;
        op_a = 32'h0; op_b = 32'h0;
        #1;
        check("reset_state", {28'd0, mdu_busy, mdu_done, 2'b00, hi}, 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            ctrl = dtab[i][14:12]; funct = dtab[i][11:6];
            #1;
            check($sformatf("decode%0d", i), 64'({alu_op, illegal, is_mdu}), 64'(dtab[i][5:0]));
        end

        run_mdu("mult_7_m3", 3'b010, 6'b011000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        ctrl = 3'b111; funct = 6'b000000; op_a = 32'd5; op_b = 32'd9; mdu_start = 1'b1;
        @(posedge clk); #1;
        mdu_start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy_done", 64'({mdu_busy, mdu_done}), 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        check("decode_in_reset", 64'({alu_op, is_mdu}), 64'b11101);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (mdu_done || mdu_busy) saw_done = 1'b1;
        end
        check("rst_no_done", 64'(saw_done), 64'd0);

        run_mdu("div_100_7", 3'b010, 6'b011010, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_mdu("div_m7_2", 3'b010, 6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_mdu("div_by0", 3'b010, 6'b011010, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1);
        run_mdu("div_min_m1", 3'b010, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        run_mdu("mult_ctrl7", 3'b111, 6'b000000, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'd6, 33);

`ifdef MDU_UNSIGNED_EN
        ctrl = 3'b010; funct = 6'b011001; #1;
        check("multu_decode", 64'({alu_op, illegal, is_mdu}), 64'b111001);
        run_mdu("multu", 3'b010, 6'b011001, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 33);
        run_mdu("divu", 3'b010, 6'b011011, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 33);
`else
        @(negedge clk);
        ctrl = 3'b010; funct = 6'b011001; op_a = 32'hFFFF_FFFF; op_b = 32'd2;
        #1;
        check("multu_illegal", 64'({alu_op, illegal, is_mdu}), 64'b000010);
        mdu_start = 1'b1;
        @(posedge clk); #1;
        check("multu_no_launch", 64'(mdu_busy), 64'd0);
        funct = 6'b011011;
        #1;
        check("divu_illegal", 64'({alu_op, illegal, is_mdu}), 64'b000010);
        @(posedge clk); #1;
        check("divu_no_launch", 64'(mdu_busy), 64'd0);
        mdu_start = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
